alu_cmd_issuer: RTL
===================

// Module: alu_cmd_issuer
// PURPOSE
//   Command-side driver of ALU_processor: accepts register-operand ALU commands (valid/ready),
//   reads operands from an internal register file, drives opcode/op1/op2 and the stored NZCV,
//   captures result and new NZCV, writes back, returns a response (valid/ready). Sits between
//   instruction decode and the combinational ALU; one command in flight.
// PARAMETERS
//   N      32  datapath width (ALU operand/result width)
//   REGS   16  register-file depth; AW = $clog2(REGS) = 4
// PORTS
//   clk           in   1   clock, rising edge
//   rst           in   1   asynchronous, active-high reset
//   cmd_valid     in   1   command present
//   cmd_ready     out  1   issuer can accept command
//   cmd_opcode    in   4   ALU opcode 0..15 (AND,EOR,ORR,NOR,BIC,ADD,ADC,SUB,SBC,RSB,RSC,TEQ,CMP,CMN,MOV,MVN)
//   cmd_rd        in   AW  destination register
//   cmd_rn        in   AW  source for op1
//   cmd_rm        in   AW  source for op2
//   cmd_s         in   1   1 = update NZCV from this op
//   alu_opcode    out  4   to ALU opcode
//   alu_op1       out  N   to ALU op1
//   alu_op2       out  N   to ALU op2
//   alu_old_flags out  4   to ALU old NZCV = flag register
//   alu_out       in   N   ALU result (combinational)
//   alu_flags     in   4   ALU new NZCV (combinational)
//   rsp_valid     out  1   response present
//   rsp_ready     in   1   consumer accepts response
//   rsp_result    out  N   captured ALU result
//   rsp_flags     out  4   flag register value after this command
//   wr_en         in   1   host preload write strobe
//   wr_addr       in   AW  host preload address
//   wr_data       in   N   host preload data
//   rd_addr       in   AW  host debug read address
//   rd_data       out  N   regfile[rd_addr], combinational
// BEHAVIOUR
//   Reset (async, rst=1): state=IDLE; regfile all 0; flags=4'b0000; alu_opcode/op1/op2=0;
//     rsp_valid=0, rsp_result=0, rsp_flags=0; cmd_ready=1 once rst released. Reset mid-command
//     aborts it: no writeback, no response.
//   FSM IDLE -> OPER -> EXEC -> RESP -> IDLE.
//   IDLE: cmd_ready=1. cmd_valid&cmd_ready at edge T0 latches opcode/rd/s, loads
//     alu_op1=reg[rn], alu_op2=reg[rm], alu_opcode=cmd_opcode -> OPER. No other state
//     asserts cmd_ready.
//   OPER: one settle cycle; ALU inputs held stable -> EXEC.
//   EXEC: at edge T2: rsp_result<=alu_out; if opcode not in {11,12,13}, reg[rd]<=alu_out;
//     if cmd_s=1 or opcode in {11,12,13}, flags<=alu_flags; rsp_flags<=resulting flags;
//     rsp_valid<=1 -> RESP.
//   RESP: rsp_valid held with stable rsp_result/rsp_flags until rsp_ready=1 at an edge;
//     then rsp_valid<=0 -> IDLE. Earliest next accept is the cycle after return to IDLE
//     (max throughput: 1 command / 4 cycles).
//   Latency: accept T0 -> rsp_valid high after T2 edge (3rd cycle after accept).
//   alu_old_flags = flag register at all times; ALU ADC/SBC/RSC use flags as of T0.
//   Compare ops TEQ/CMP/CMN: never write regfile; always update flags; rsp_result still the ALU out.
//   Operands are registered at T0; later host writes to rn/rm do not affect the command.
//   rn==rm legal; rd may equal rn/rm (writeback at T2 only).
//   wr_en honoured in any state; same-edge collision with EXEC writeback to same
//     address: writeback wins. Different addresses: both written.
//   rd_data reflects writes from the following cycle.
//   All arithmetic is done in the ALU; the issuer never modifies result or flag bits.
// TESTING
//   1 preload r1=1234,r2=1234; ADD rd=3,rn=1,rm=2,s=1 -> rsp_valid 3 cycles after accept,
//     rsp_result=2468, r3=2468, rsp_flags=ALU NZCV, N=0 Z=0
//   2 r1=1234,r2=1234; SUB rd=4,s=1 -> rsp_result=0, Z=1 in rsp_flags and alu_old_flags
//     afterwards; then ADD s=0 -> flags unchanged
//   3 r5=9999,r6=1111; CMP rd=7 -> rsp_result=8888, r7 unchanged (0), flags updated
//     although s=0
//   4 hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_result stable; cmd_ready=0;
//     cmd_valid ignored; response pops on first rsp_ready=1 edge
//   5 EXEC with rd=3 and wr_en, wr_addr=3, wr_data=7 same edge -> r3=ALU result;
//     wr_addr=8 -> both writes land
//   6 assert rst during OPER -> flags=0000, regfile=0, rsp_valid never asserts;
//     new command after release completes normally

Source files
------------

// File: rtl/alu_cmd_issuer.sv
// Command-side driver for a combinational ALU: regfile read, operand issue, result/flag writeback.
// One command in flight; accept -> response valid after 3 edges; response held until rsp_ready.
module alu_cmd_issuer #(
  parameter int N    = 32,
  parameter int REGS = 16,
  parameter int AW   = $clog2(REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_opcode,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rn,
  input  logic [AW-1:0] cmd_rm,
  input  logic          cmd_s,
  output logic [3:0]    alu_opcode,
  output logic [N-1:0]  alu_op1,
  output logic [N-1:0]  alu_op2,
  output logic [3:0]    alu_old_flags,
  input  logic [N-1:0]  alu_out,
  input  logic [3:0]    alu_flags,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [N-1:0]  rsp_result,
  output logic [3:0]    rsp_flags,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [N-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [N-1:0]  rd_data
);

  typedef enum logic [1:0] {IDLE, OPER, EXEC, RESP} state_t;

  state_t        state;
  logic [N-1:0]  regs [REGS];
  logic [3:0]    flags;
  logic [AW-1:0] rd_q;
  logic          s_q;
  logic          is_cmp;
  logic [3:0]    flags_new;

  // alu_opcode holds the latched opcode for the whole command
  assign is_cmp        = (alu_opcode == 4'd11) || (alu_opcode == 4'd12) || (alu_opcode == 4'd13);
  assign flags_new     = (s_q || is_cmp) ? alu_flags : flags;
  assign cmd_ready     = (state == IDLE);
  assign alu_old_flags = flags;
  assign rd_data       = regs[rd_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      flags      <= 4'b0000;
      alu_opcode <= 4'd0;
      alu_op1    <= '0;
      alu_op2    <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= 4'b0000;
      rd_q       <= '0;
      s_q        <= 1'b0;
      for (int i = 0; i < REGS; i++) regs[i] <= '0;
    end else begin
      // Host write first so a same-address EXEC writeback below overrides it
      if (wr_en) regs[wr_addr] <= wr_data;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            alu_opcode <= cmd_opcode;
            alu_op1    <= regs[cmd_rn];
            alu_op2    <= regs[cmd_rm];
            rd_q       <= cmd_rd;
            s_q        <= cmd_s;
            state      <= OPER;
          end
        end
        OPER: state <= EXEC;
        EXEC: begin
          rsp_result <= alu_out;
          if (!is_cmp) regs[rd_q] <= alu_out;
          flags      <= flags_new;
          rsp_flags  <= flags_new;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
